user_btn_reader: RTL

- Input-side counterpart to the LED counter output path: samples asynchronous board push-buttons/switches (user_btn) into the sys_clk domain.
- Debounces each input and reports a clean level, one-cycle edge pulses, and a queued event stream over a valid/ready handshake.
- Sits between board pins and the SoC event/CSR logic.

---
 rtl/user_btn_pkg.sv | 15 +
 rtl/btn_debounce.sv | 80 ++++++++
 rtl/user_btn_reader.sv | 116 +++++++++++
 3 files changed

// File: rtl/user_btn_pkg.sv
// Shared event-kind encoding and index-width helper for the button reader.
package user_btn_pkg;

   typedef enum logic [1:0] {
      EVT_REL   = 2'd0,
      EVT_PRESS = 2'd1,
      EVT_LONG  = 2'd2,
      EVT_RSVD  = 2'd3
   } evt_kind_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, tick-driven debounce, edge pulses.
// Optional hold counter for long-press detection under USER_BTN_LONGPRESS_EN.
module btn_debounce
   import user_btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS  = 20,
   parameter int unsigned LONGPRESS_TICKS = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   input  logic tick,
   output logic level,
   output logic rise,
   output logic fall,
   output logic long_press
);

   localparam int unsigned CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == CNT_LAST) begin
               level <= ~level;
               cnt   <= '0;
               rise  <= ~level;
               fall  <= level;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

`ifdef USER_BTN_LONGPRESS_EN
   localparam int unsigned HW = $clog2(LONGPRESS_TICKS + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONGPRESS_TICKS - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONGPRESS_TICKS);

   logic [HW-1:0] hold;

   // Saturation at HOLD_MAX guarantees a single long-press pulse per press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold       <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= 1'b0;
         if (!level) begin
            hold <= '0;
         end else if (tick && (hold != HOLD_MAX)) begin
            hold <= hold + HW'(1);
            if (hold == HOLD_LAST) long_press <= 1'b1;
         end
      end
   end
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: rtl/user_btn_reader.sv
// Debounced button reader: per-channel levels/edges plus a valid/ready event queue.
// Long-press events are built only when USER_BTN_LONGPRESS_EN is defined.
module user_btn_reader
   import user_btn_pkg::*;
#(
   parameter int unsigned N_BTN           = 4,
   parameter int unsigned TICK_DIV        = 32000,
   parameter int unsigned DEBOUNCE_TICKS  = 20,
   parameter int unsigned LONGPRESS_TICKS = 1000
) (
   input  logic                              sys_clk,
   input  logic                              sys_rst_n,
   input  logic [N_BTN-1:0]                  user_btn,
   output logic [N_BTN-1:0]                  btn_level,
   output logic [N_BTN-1:0]                  btn_rise,
   output logic [N_BTN-1:0]                  btn_fall,
   output logic                              evt_valid,
   input  logic                              evt_ready,
   output logic [idx_width(N_BTN)-1:0]       evt_idx,
   output logic [1:0]                        evt_kind,
   output logic                              evt_overflow,
   input  logic                              ovf_clr
);

   localparam int unsigned IDXW = idx_width(N_BTN);
   localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0]    presc;
   logic             tick;
   logic [N_BTN-1:0] long_p;
   logic [N_BTN-1:0] pend_press, pend_long, pend_rel;
   logic [N_BTN-1:0] clr_press, clr_long, clr_rel, issue_mask;
   logic             sel_valid, load, issue, ovf_new;
   logic [IDXW-1:0]  sel_idx;
   evt_kind_t        sel_kind;

   assign tick = (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) presc <= '0;
      else            presc <= tick ? '0 : presc + PW'(1);
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .LONGPRESS_TICKS(LONGPRESS_TICKS)
      ) u_deb (
         .clk       (sys_clk),
         .rst_n     (sys_rst_n),
         .pin       (user_btn[i]),
         .tick      (tick),
         .level     (btn_level[i]),
         .rise      (btn_rise[i]),
         .fall      (btn_fall[i]),
         .long_press(long_p[i])
      );
   end

   // Lowest index wins; within a channel press, then long, then release.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      sel_kind  = EVT_REL;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (!sel_valid) begin
            if (pend_press[i]) begin
               sel_valid = 1'b1; sel_idx = IDXW'(i); sel_kind = EVT_PRESS;
            end else if (pend_long[i]) begin
               sel_valid = 1'b1; sel_idx = IDXW'(i); sel_kind = EVT_LONG;
            end else if (pend_rel[i]) begin
               sel_valid = 1'b1; sel_idx = IDXW'(i); sel_kind = EVT_REL;
            end
         end
      end
   end

   assign load  = !evt_valid || evt_ready;
   assign issue = load && sel_valid;

   always_comb begin
      issue_mask = issue ? (N_BTN'(1) << sel_idx) : '0;
      clr_press  = (sel_kind == EVT_PRESS) ? issue_mask : '0;
      clr_long   = (sel_kind == EVT_LONG)  ? issue_mask : '0;
      clr_rel    = (sel_kind == EVT_REL)   ? issue_mask : '0;
      // A set that lands on a bit being issued this cycle is not a loss.
      ovf_new    = |((btn_rise & pend_press & ~clr_press) |
                     (long_p   & pend_long  & ~clr_long)  |
                     (btn_fall & pend_rel   & ~clr_rel));
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pend_press   <= '0;
         pend_long    <= '0;
         pend_rel     <= '0;
         evt_valid    <= 1'b0;
         evt_idx      <= '0;
         evt_kind     <= '0;
         evt_overflow <= 1'b0;
      end else begin
         pend_press   <= btn_rise | (pend_press & ~clr_press);
         pend_long    <= long_p   | (pend_long  & ~clr_long);
         pend_rel     <= btn_fall | (pend_rel   & ~clr_rel);
         evt_overflow <= ovf_new | (evt_overflow & ~ovf_clr);
         if (load) begin
            evt_valid <= sel_valid;
            if (sel_valid) begin
               evt_idx  <= sel_idx;
               evt_kind <= sel_kind;
            end
         end
      end
   end

endmodule
